// File: rtl/boot_rom_reader.sv
// Boot ROM block reader: paced ROM reads into a 2-entry FWFT skid FIFO.
// Optional running checksum output under BOOT_ROM_READER_CHECKSUM_EN.
module boot_rom_reader #(
  parameter int ROM_ADDR_WIDTH = 13,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  output logic                 rom_csn_o,
  output logic [31:0]          rom_add_o,
  input  logic [31:0]          rom_rdata_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 done_o
`ifdef BOOT_ROM_READER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum_o
`endif
);

  localparam int AW = ROM_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [CNT_WIDTH-1:0] left_q, left_d;
  logic                 infl_q, infl_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [31:0]          mem_q [2];
  logic [31:0]          mem_d [2];

  logic       pop;
  logic       issue;
  logic       start_ok;
  logic [1:0] occ;
  logic       unused_base;

  assign unused_base = ^{base_addr_i[31:ROM_ADDR_WIDTH],
                         base_addr_i[1:0]};

  // occupancy the FIFO will see once in-flight data lands
  always_comb begin
    pop      = (cnt_q != 2'd0) && ready_i;
    occ      = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    issue    = (state_q == RUN) && (left_q != '0)
               && (occ < 2'd2);
    start_ok = (state_q == IDLE) && start_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (left_q == CNT_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!infl_q && (occ == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    left_d   = left_q;
    infl_d   = issue;
    cnt_d    = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    wr_d     = wr_q ^ infl_q;
    rd_d     = rd_q ^ pop;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (start_ok) begin
      addr_d = base_addr_i[ROM_ADDR_WIDTH-1:2];
      left_d = num_words_i;
    end else if (issue) begin
      addr_d = addr_q + AW'(1);
      left_d = left_q - CNT_WIDTH'(1);
    end
    if (infl_q) begin
      mem_d[wr_q] = rom_rdata_i;
    end
  end

  always_comb begin
    rom_csn_o = !issue;
    rom_add_o = {{(32-ROM_ADDR_WIDTH){1'b0}}, addr_q, 2'b00};
    valid_o   = (cnt_q != 2'd0);
    data_o    = mem_q[rd_q];
    busy_o    = (state_q == RUN) || (state_q == DRAIN);
    done_o    = (state_q == DONE);
  end

`ifdef BOOT_ROM_READER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok) begin
      sum_d = '0;
    end else if (pop) begin
      sum_d = sum_q + data_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum_o = sum_q;
`endif

endmodule
